// File: rtl/paddle_input_arbiter.sv
// paddle_input_arbiter: per-paddle ownership FSM arbitrating accel tilt, UART commands and buttons into up/down move requests
// Ports: clk, reset_n (async active-low), tick_1ms (1 ms enable),
//   accel_x/accel_y + accel_valid (signed tilt samples for paddle1/paddle2),
//   rx_dv + rx_byte (UART command: [0] P1 dn, [1] P1 up, [2] P2 dn, [3] P2 up),
//   btn (debounced: [0] P1 dn, [1] P1 up, [2] P2 dn, [3] P2 up),
//   p1_up/p1_dn/p2_up/p2_dn (move requests), p1_src/p2_src (owner: 00 none, 01 accel, 10 uart, 11 button)
module paddle_input_arbiter #(
    parameter int TILT_THRESH = 64,
    parameter int HOLD_MS     = 150,
    parameter int IDLE_MS     = 2000,
    parameter int AW          = 17
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tick_1ms,
    input  logic [AW-1:0] accel_x,
    input  logic [AW-1:0] accel_y,
    input  logic          accel_valid,
    input  logic          rx_dv,
    input  logic [7:0]    rx_byte,
    input  logic [3:0]    btn,
    output logic          p1_up,
    output logic          p1_dn,
    output logic          p2_up,
    output logic          p2_dn,
    output logic [1:0]    p1_src,
    output logic [1:0]    p2_src
);
    localparam int CW = $clog2(((HOLD_MS > IDLE_MS) ? HOLD_MS : IDLE_MS) + 1);
    localparam logic [1:0] S_NONE = 2'b00, S_ACC = 2'b01, S_UART = 2'b10, S_BTN = 2'b11;
    localparam logic signed [AW-1:0] POS = AW'(TILT_THRESH);
    localparam logic signed [AW-1:0] NEG = -POS;
    logic unused_hi;
    assign unused_hi = ^rx_byte[7:4];
    for (genvar i = 0; i < 2; i++) begin : g_pad
        logic signed [AW-1:0] acc;
        logic [1:0] cmd, b, st, st_nx;
        logic [CW-1:0] hold, idle;
        logic up, dn, acc_act, uart_act, btn_act, own_act, own_up, own_dn, timeout;
        assign b = btn[2*i +: 2];
        always_comb begin
            acc_act  = acc > POS || acc < NEG;
            uart_act = hold != '0 && cmd != 2'b00;
            btn_act  = b != 2'b00;
            st_nx    = btn_act ? S_BTN :
                       (uart_act && (st == S_NONE || st == S_ACC)) ? S_UART :
                       (acc_act && st == S_NONE) ? S_ACC : st;
            own_act  = st_nx == S_BTN ? btn_act : st_nx == S_UART ? uart_act :
                       st_nx == S_ACC ? acc_act : 1'b0;
            // both-pressed / both-set decodes to zero motion; inactive sources decode to 00
            {own_up, own_dn} = st_nx == S_BTN  ? {b[1] & ~b[0], b[0] & ~b[1]} :
                               st_nx == S_UART ? (hold != '0 ? {cmd[1] & ~cmd[0], cmd[0] & ~cmd[1]} : 2'b00) :
                               st_nx == S_ACC  ? {acc > POS, acc < NEG} : 2'b00;
            // this tick would be the IDLE_MS-th consecutive inactive tick of an unchanged owner
            timeout  = st_nx == st && st != S_NONE && !own_act && idle == CW'(IDLE_MS - 1);
        end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc  <= '0;
                cmd  <= 2'b00;
                hold <= '0;
                idle <= '0;
                st   <= S_NONE;
                up   <= 1'b0;
                dn   <= 1'b0;
            end else begin
                if (accel_valid)
                    acc <= (i == 0) ? accel_x : accel_y;
                if (rx_dv) begin
                    cmd  <= rx_byte[2*i +: 2];
                    hold <= CW'(HOLD_MS);
                end else if (tick_1ms && hold != '0)
                    hold <= hold - CW'(1);
                if (tick_1ms) begin
                    st   <= timeout ? S_NONE : st_nx;
                    idle <= (timeout || st_nx != st || own_act || st_nx == S_NONE) ? '0 : idle + CW'(1);
                    up   <= own_up;
                    dn   <= own_dn;
                end
            end
        end
    end
    assign p1_up  = g_pad[0].up;
    assign p1_dn  = g_pad[0].dn;
    assign p1_src = g_pad[0].st;
    assign p2_up  = g_pad[1].up;
    assign p2_dn  = g_pad[1].dn;
    assign p2_src = g_pad[1].st;
endmodule

// File: tb/tb_paddle_input_arbiter.sv
// tb_paddle_input_arbiter: scoreboard bench for paddle_input_arbiter, expected word is {p1_src,p2_src,p1_up,p1_dn,p2_up,p2_dn}
module tb_paddle_input_arbiter;
    logic clk = 1'b0, reset_n = 1'b1, tick_1ms = 1'b0, accel_valid = 1'b0, rx_dv = 1'b0;
    logic [16:0] accel_x = '0, accel_y = '0;
    logic [7:0] rx_byte = '0;
    logic [3:0] btn = '0;
    logic p1_up, p1_dn, p2_up, p2_dn;
    logic [1:0] p1_src, p2_src;
    logic [7:0] dut_v;
    int n_tests = 0, n_fail = 0;
    typedef struct {
        bit         chk;
        logic [7:0] v;
        string      name;
    } exp_t;
    exp_t sb[$];
    paddle_input_arbiter dut (
        .clk(clk), .reset_n(reset_n), .tick_1ms(tick_1ms),
        .accel_x(accel_x), .accel_y(accel_y), .accel_valid(accel_valid),
        .rx_dv(rx_dv), .rx_byte(rx_byte), .btn(btn),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .p1_src(p1_src), .p2_src(p2_src)
    );
    always #5 clk = ~clk;
    assign dut_v = {p1_src, p2_src, p1_up, p1_dn, p2_up, p2_dn};
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b_%b_%b required %b_%b_%b (src1_src2_moves)",
                     name, act[7:6], act[5:4], act[3:0], exp[7:6], exp[5:4], exp[3:0]);
        end
    endtask
    always @(posedge clk) begin
        exp_t e;
        if (reset_n && tick_1ms) begin
            #1;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got tick with empty scoreboard, required an expected entry");
            end else begin
                e = sb.pop_front();
                if (e.chk)
                    check(e.name, dut_v, e.v);
            end
        end
    end
    task automatic tick(input bit c, input string nm, input logic [7:0] v);
        exp_t e;
        e.chk = c;
        e.name = nm;
        e.v = v;
        @(negedge clk);
        tick_1ms = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        tick_1ms = 1'b0;
    endtask
    task automatic skip(input int n);
        repeat (n) tick(1'b0, "", 8'h00);
    endtask
    task automatic send_accel(input int x, input int y);
        @(negedge clk);
        accel_x = x[16:0];
        accel_y = y[16:0];
        accel_valid = 1'b1;
        @(negedge clk);
        accel_valid = 1'b0;
    endtask
    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_dv = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask
    task automatic send_rx_tick(input logic [7:0] b, input string nm, input logic [7:0] v);
        exp_t e;
        e.chk = 1'b1;
        e.name = nm;
        e.v = v;
        @(negedge clk);
        rx_byte = b;
        rx_dv = 1'b1;
        tick_1ms = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        rx_dv = 1'b0;
        tick_1ms = 1'b0;
    endtask
    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", dut_v, 8'h00);
        reset_n = 1'b1;
        send_accel(100, 0);
        tick(1, "acc_grab", 8'b01_00_10_00);
        tick(1, "acc_hold", 8'b01_00_10_00);
        send_accel(64, 0);
        tick(1, "acc_thresh_pos", 8'b01_00_00_00);
        send_accel(-65, 0);
        tick(1, "acc_neg", 8'b01_00_01_00);
        send_accel(-64, 0);
        tick(1, "acc_thresh_neg", 8'b01_00_00_00);
        send_accel(200, 0);
        tick(1, "acc_200", 8'b01_00_10_00);
        send_rx(8'h01);
        tick(1, "uart_preempt", 8'b10_00_01_00);
        skip(148);
        tick(1, "uart_t150", 8'b10_00_01_00);
        tick(1, "uart_t151", 8'b10_00_00_00);
        skip(1997);
        tick(1, "uart_idle_1999", 8'b10_00_00_00);
        tick(1, "uart_idle_timeout", 8'b00_00_00_00);
        tick(1, "regrab_acc", 8'b01_00_10_00);
        send_rx(8'h02);
        tick(1, "uart_over_acc", 8'b10_00_10_00);
        @(negedge clk);
        btn = 4'b0010;
        tick(1, "btn_preempt", 8'b11_00_10_00);
        @(negedge clk);
        btn = 4'b0000;
        send_accel(0, 0);
        tick(1, "btn_release", 8'b11_00_00_00);
        skip(1997);
        tick(1, "btn_idle_1999", 8'b11_00_00_00);
        tick(1, "btn_timeout", 8'b00_00_00_00);
        @(negedge clk);
        btn = 4'b1100;
        send_rx(8'h08);
        tick(1, "p2_btn_both", 8'b00_11_00_00);
        @(negedge clk);
        btn = 4'b0000;
        tick(1, "p2_btn_idle", 8'b00_11_00_00);
        send_rx_tick(8'h01, "rx_coincident", 8'b00_11_00_00);
        tick(1, "rx_next_tick", 8'b10_11_01_00);
        skip(68);
        tick(1, "pre_reset", 8'b10_11_01_00);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset", dut_v, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        tick(1, "post_reset", 8'h00);
        send_accel(-65536, 65);
        tick(1, "acc_min_p2_up", 8'b01_01_01_10);
        send_accel(-64, -65536);
        tick(1, "acc_edge_p2_min", 8'b01_01_00_01);
        send_accel(65535, -65);
        tick(1, "acc_max", 8'b01_01_10_01);
        send_rx(8'h04);
        tick(1, "p2_uart_only", 8'b01_10_10_01);
        send_rx(8'h06);
        tick(1, "rx_both_paddles", 8'b10_10_10_01);
        for (int k = 0; k < 100 && sb.size() != 0; k++)
            @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: got %0d pending entries, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/paddle_input_arbiter.md
Name: paddle_input_arbiter

Overview:
- Shares control of each paddle between three input sources: accelerometer tilt (moving-average X/Y), UART command bytes, and debounced push buttons.
- Runs one ownership FSM per paddle. It resolves priority and idle release, and produces clean, mutually exclusive up/down move strobes on every 1 ms game tick.
- Sits between the input front-ends (MovingAverage, uart_rx, debouncers) and the paddle block, replacing their direct wiring.

Parameters:
- TILT_THRESH, 64: tilt magnitude (LSB) that counts as a move; the comparison is strict.
- HOLD_MS, 150: number of ticks a UART move command stays asserted after each byte.
- IDLE_MS, 2000: number of consecutive inactive owner ticks before ownership is released.
- AW, 17: width of the signed accelerometer inputs.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tick_1ms  in  1  one-cycle enable, once per ms
- accel_x  in  AW  signed tilt for paddle1 (two's complement)
- accel_y  in  AW  signed tilt for paddle2
- accel_valid  in  1  one-cycle strobe; samples accel_x/accel_y
- rx_dv  in  1  one-cycle strobe; rx_byte valid
- rx_byte  in  8  [0]=P1 down, [1]=P1 up, [2]=P2 down, [3]=P2 up, [7:4] ignored
- btn  in  4  debounced, active-high: [0]=P1 down, [1]=P1 up, [2]=P2 down, [3]=P2 up
- p1_up, p1_dn  out  1  paddle1 move request (level, updated on tick)
- p2_up, p2_dn  out  1  paddle2 move request
- p1_src, p2_src  out  2  current owner: 00 none, 01 accel, 10 uart, 11 button

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0. Owners go to NONE. Hold and idle counters clear. Latched accel/UART values clear. Asserting reset mid-operation aborts immediately; nothing persists through it.
- Sampling:
  - On accel_valid, latch accel_x/accel_y.
  - On rx_dv, latch the paddle's two command bits into that paddle's UART register and load its hold counter with HOLD_MS.
  - A strobe that coincides with tick_1ms takes effect at the following tick.
- Per-paddle source requests, evaluated only on tick_1ms:
  - ACCEL: up if latched value > +TILT_THRESH; down if < -TILT_THRESH. Use a signed compare, with no abs() (so -2^(AW-1) is handled correctly). Exactly ±TILT_THRESH is inactive.
  - UART: active while hold>0. It gives up/down from the latched bits. Both bits set means active with zero motion; both clear means inactive. On each tick, hold decrements and saturates at 0.
  - BTN: active when either paddle button is high. Both buttons high means active with zero motion.
- FSM per paddle, with states NONE, ACCEL, UART, BTN. Transitions happen only on tick.
  - NONE: grab the highest-priority active source (BTN > UART > ACCEL). Stay in NONE if no source is active.
  - Any owner state: BTN activity preempts immediately. UART preempts ACCEL only. A lower-priority source never preempts a higher one.
  - Idle counter: cleared on each tick the owner is active or on any ownership change; incremented on inactive ticks. When it reaches IDLE_MS, go to NONE with outputs 0 on that same tick. The next tick may regrab.
- Outputs:
  - Registered, updated one clk after the tick cycle, and held between ticks.
  - Each paddle's outputs come only from its owner's request; non-owner requests are ignored.
  - up and dn are never both 1. The src output reflects the post-transition owner.
  - An inactive owner (before timeout) drives up=dn=0.
- The two paddles are fully independent. A single rx_byte can feed both paddles in the same cycle.
- Counter widths must hold max(HOLD_MS, IDLE_MS) without wrap.

Test Plan:
- Reset, then accel_x=+100 with accel_valid, then 2 ticks → p1_src=01, p1_up=1 one clk after the first tick. accel_x=+64 → p1_up=0 (strict threshold). accel_x=-65 → p1_dn=1.
- p1 owned by accel (accel_x=+200), then rx_byte=8'h01 with rx_dv → next tick p1_src=10, p1_dn=1, held 150 ticks. At tick 151: p1_dn=0 and src stays 10. After 2000 further ticks: src=01 if accel is still tilted.
- p1 owned by UART, then btn[1]=1 → next tick p1_src=11, p1_up=1. btn released → src stays 11, outputs 0. After 2000 ticks → src=00.
- btn[3:2]=2'b11 plus rx_byte=8'h08 on the same tick → p2_src=11, p2_up=p2_dn=0. p1 is unaffected (p1_src=00).
- rx_dv coincident with tick_1ms → no change at that tick; the command appears at the next tick. accel_x=-65536 → p1_dn=1.
- reset_n low mid-hold (hold=80, src=10) → all outputs and src are 0 asynchronously. After release, no residual UART command on the next tick.
